hqm_aw_elastic_buffer: RTL and testbench

Parametrised valid/ready elastic buffer for synchronous-clock PAR receive interfaces. It generalises the fixed four-entry decoupling buffer to any `DEPTH` of 2 or more. It adds a programmable high watermark for backpressure, a synchronous flush, and a peak-occupancy monitor. It sits between a PAR receiver and the consuming pipeline, and decouples input timing from output timing with a registered `in_ready`.

---
 rtl/hqm_aw_elastic_buffer_pkg.sv | 22 ++
 rtl/hqm_aw_elastic_buffer.sv | 138 +++++++++++++
 tb/tb_hqm_aw_elastic_buffer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hqm_aw_elastic_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hqm_aw_elastic_buffer_pkg
//  Description : Shared status-field bit positions for elastic buffer hookups.
//  Revision    : 1.0
// ============================================================================
package hqm_aw_elastic_buffer_pkg;

    // Handshake fields sit directly above the DW-bit depth field of status.
    localparam int EB_ST_OUT_READY = 0;
    localparam int EB_ST_OUT_TAKEN = 1;
    localparam int EB_ST_OUT_STALL = 2;
    localparam int EB_ST_IN_TAKEN  = 3;
    localparam int EB_ST_IN_STALL  = 4;
    localparam int EB_ST_NUM_HS    = 5;

    function automatic int eb_status_bit(input int dw, input int field);
        return dw + field;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hqm_aw_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : hqm_aw_elastic_buffer
//  Description : Parametrised valid/ready elastic buffer with watermark,
//                flush and peak-occupancy monitor.
//  Revision    : 1.0
// ============================================================================
module hqm_aw_elastic_buffer
    import hqm_aw_elastic_buffer_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 4,
    parameter int IN_READY_WIDTH = 1,
    parameter int RESET_DATAPATH = 0,
    localparam int DW            = $clog2(DEPTH + 1),
    localparam int PW            = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [IN_READY_WIDTH-1:0] in_ready,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic [DW-1:0]             cfg_hwm,
    input  logic                      flush,
    input  logic                      clr_peak,
    output logic [EB_ST_NUM_HS+DW-1:0] status,
    output logic [DW-1:0]             peak_depth
);

    localparam logic [DW-1:0] C_DEPTH    = DW'(DEPTH);
    localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);

    logic [IN_READY_WIDTH-1:0] in_ready_q, in_ready_d;
    logic [DW-1:0]             depth_q, depth_d;
    logic [DW-1:0]             peak_q, peak_d;
    logic [PW-1:0]             wp_q, wp_d;
    logic [PW-1:0]             rp_q, rp_d;
    logic [EB_ST_NUM_HS-1:0]   st_hs_q, st_hs_d;
    logic [DW-1:0]             hwm_eff;
    logic [DEPTH*WIDTH-1:0]    data_q;
    logic [DEPTH-1:0]          entry_we;
    logic                      in_taken, in_stall, out_taken, out_stall;

    assign out_valid  = (depth_q != '0);
    assign in_ready   = in_ready_q;
    assign peak_depth = peak_q;
    assign status     = {st_hs_q, depth_q};

    always_comb begin
        in_taken  = in_valid & in_ready_q[0];
        in_stall  = in_valid & ~in_ready_q[0];
        out_taken = out_valid & out_ready;
        out_stall = out_valid & ~out_ready;

        hwm_eff = ((cfg_hwm == '0) || (cfg_hwm > C_DEPTH)) ? C_DEPTH : cfg_hwm;

        depth_d = depth_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (flush) begin
            depth_d = '0;
            wp_d    = '0;
            rp_d    = '0;
        end else begin
            if (in_taken && !out_taken) begin
                depth_d = depth_q + DW'(1);
            end else if (out_taken && !in_taken) begin
                depth_d = depth_q - DW'(1);
            end
            if (in_taken) begin
                wp_d = (wp_q == C_LAST_PTR) ? '0 : wp_q + PW'(1);
            end
            if (out_taken) begin
                rp_d = (rp_q == C_LAST_PTR) ? '0 : rp_q + PW'(1);
            end
        end

        in_ready_d = {IN_READY_WIDTH{depth_d < hwm_eff}};
        // Clearing the peak restarts tracking from the occupancy we are moving to.
        peak_d     = (clr_peak || (depth_d > peak_q)) ? depth_d : peak_q;
        st_hs_d    = {in_stall, in_taken, out_stall, out_taken, out_ready};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= '1;
            depth_q    <= '0;
            peak_q     <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            st_hs_q    <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            depth_q    <= depth_d;
            peak_q     <= peak_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            st_hs_q    <= st_hs_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [WIDTH-1:0] ent_q;

        assign entry_we[i] = in_taken & ~flush & (wp_q == PW'(i));
        assign data_q[i*WIDTH +: WIDTH] = ent_q;

        if (RESET_DATAPATH != 0) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent_q <= '0;
                end else if (entry_we[i]) begin
                    ent_q <= in_data;
                end
            end
        end else begin : g_norst
            always_ff @(posedge clk) begin
                if (entry_we[i]) begin
                    ent_q <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rp_q == PW'(i)) begin
                out_data = data_q[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hqm_aw_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hqm_aw_elastic_buffer
//  Description : Self-checking bench: vector table plus data scoreboard.
//  Revision    : 1.0
// ============================================================================
module tb_hqm_aw_elastic_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 5;
    localparam int IRW   = 2;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic [IRW-1:0]   in_ready;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [DW-1:0]    cfg_hwm;
    logic             flush;
    logic             clr_peak;
    logic [DW+4:0]    status;
    logic [DW-1:0]    peak_depth;

    hqm_aw_elastic_buffer #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .IN_READY_WIDTH (IRW),
        .RESET_DATAPATH (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_ready   (in_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .cfg_hwm    (cfg_hwm),
        .flush      (flush),
        .clr_peak   (clr_peak),
        .status     (status),
        .peak_depth (peak_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             fl;
        logic             cp;
        logic [DW-1:0]    hwm;
        int               e_depth;
        logic             e_ir;
        logic             e_ov;
        int               e_peak;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] sb[$];
    int               checks   = 0;
    int               failures = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic void add(input logic iv, input int d, input logic ordy, input logic fl,
                                input logic cp, input int hwm, input int e_depth,
                                input logic e_ir, input logic e_ov, input int e_peak);
        vec_t v;
        v.iv = iv; v.d = WIDTH'(d); v.ordy = ordy; v.fl = fl; v.cp = cp;
        v.hwm = DW'(hwm); v.e_depth = e_depth; v.e_ir = e_ir; v.e_ov = e_ov; v.e_peak = e_peak;
        vecs.push_back(v);
    endfunction

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic cycle(input string nm);
        logic it, ot, is, os;
        #4;
        it = in_valid & in_ready[0];
        is = in_valid & ~in_ready[0];
        ot = out_valid & out_ready;
        os = out_valid & ~out_ready;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_sb_empty actual=out_valid expected=no_data", nm);
            end else begin
                chk({nm, "_out_data"}, 64'(out_data), 64'(sb[0]));
            end
        end
        @(posedge clk);
        #1;
        if (ot && sb.size() > 0) void'(sb.pop_front());
        if (flush) sb.delete();
        else if (it) sb.push_back(in_data);
        chk({nm, "_status_hs"}, 64'(status[DW+4:DW]), 64'({is, it, os, ot, out_ready}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_hwm = '0; flush = 1'b0; clr_peak = 1'b0;

        // Fill to full with hwm=0 (treated as DEPTH), then a stalled input.
        for (int k = 0; k < 5; k++) add(1, k, 0, 0, 0, 0, k + 1, k < 4, 1, k + 1);
        add(1, 99, 0, 0, 0, 0, 5, 0, 1, 5);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 0, 0, 4 - k, 1, k < 4, 5);
        // Depth-1 streaming, pointers wrap repeatedly.
        add(1, 20, 0, 0, 0, 0, 1, 1, 1, 5);
        for (int k = 0; k < 10; k++) add(1, 21 + k, 1, 0, 0, 0, 1, 1, 1, 5);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 5);
        // Peak clear at depth 2, then flush at depth 3 with a concurrent input.
        add(1, 40, 0, 0, 0, 0, 1, 1, 1, 5);
        add(1, 41, 0, 0, 0, 0, 2, 1, 1, 5);
        add(0, 0, 0, 0, 1, 0, 2, 1, 1, 2);
        add(1, 42, 0, 0, 0, 0, 3, 1, 1, 3);
        add(1, 43, 0, 1, 0, 0, 0, 1, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        add(1, 50, 0, 0, 0, 0, 1, 1, 1, 3);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 3);
        // Watermark 2 under continuous input, then lowered to 1 below depth.
        add(1, 60, 0, 0, 0, 2, 1, 1, 1, 3);
        add(1, 61, 0, 0, 0, 2, 2, 0, 1, 3);
        add(1, 62, 0, 0, 0, 2, 2, 0, 1, 3);
        add(1, 63, 0, 0, 0, 2, 2, 0, 1, 3);
        add(0, 0, 0, 0, 0, 1, 2, 0, 1, 3);
        add(0, 0, 1, 0, 0, 1, 1, 0, 1, 3);
        add(0, 0, 1, 0, 0, 1, 0, 1, 0, 3);
        // Watermark above DEPTH clamps to DEPTH; leave depth at 3.
        for (int k = 0; k < 5; k++) add(1, 70 + k, 0, 0, 0, 7, k + 1, k < 4, 1, (k + 1 > 3) ? k + 1 : 3);
        add(0, 0, 1, 0, 0, 7, 4, 1, 1, 5);
        add(0, 0, 1, 0, 0, 7, 3, 1, 1, 5);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'({IRW{1'b1}}));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_peak", 64'(peak_depth), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
            flush = vecs[i].fl; clr_peak = vecs[i].cp; cfg_hwm = vecs[i].hwm;
            cycle(nm);
            chk({nm, "_depth"}, 64'(status[DW-1:0]), 64'(vecs[i].e_depth));
            chk({nm, "_in_ready"}, 64'(in_ready), 64'({IRW{vecs[i].e_ir}}));
            chk({nm, "_out_valid"}, 64'(out_valid), 64'(vecs[i].e_ov));
            chk({nm, "_peak"}, 64'(peak_depth), 64'(vecs[i].e_peak));
            if (vecs[i].hwm == DW'(2) && vecs[i].e_depth == 2 && vecs[i].iv)
                chk({nm, "_in_stall_bit"}, 64'(status[4+DW]), 64'(vecs[i].d != WIDTH'(61)));
        end

        // Asynchronous reset mid-operation with three entries stored.
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clr_peak = 1'b0; cfg_hwm = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'({IRW{1'b1}}));
        chk("mid_rst_status", 64'(status), 64'(0));
        chk("mid_rst_peak", 64'(peak_depth), 64'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 16'h1234;
        cycle("post_rst_wr");
        chk("post_rst_depth", 64'(status[DW-1:0]), 64'(1));
        chk("post_rst_out_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0; out_ready = 1'b1;
        cycle("post_rst_rd");
        chk("post_rst_drained", 64'(status[DW-1:0]), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
